// File: rtl/spi_flash_arbiter.sv
// Two-requester arbiter in front of a single-bit SPI boot flash.
// Each grant runs one READ (0x03) and returns a little-endian 32-bit word.
module spi_flash_arbiter #(
    parameter int unsigned CLK_DIV = 1,
    parameter int unsigned CS_GAP  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic [23:0] m0_addr,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [23:0] m1_addr,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        flash_clk,
    output logic        flash_csn,
    output logic        flash_io0_en,
    output logic        flash_io0_out,
    input  logic        flash_io0_in,
    output logic        flash_io1_en,
    output logic        flash_io1_out,
    input  logic        flash_io1_in,
    output logic        busy,
    output logic        grant_id
);

    localparam int unsigned DivW = $clog2(CLK_DIV + 1);
    localparam int unsigned GapW = $clog2(CS_GAP + 1);

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

    state_e           state_q, state_d;
    logic [63:0]      shift_q, shift_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [DivW-1:0]  div_cnt_q, div_cnt_d;
    logic             sclk_q, sclk_d;
    logic [31:0]      rx_q, rx_d;
    logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_id_q, grant_id_d;
    logic             m0_ready_q, m0_ready_d;
    logic             m1_ready_q, m1_ready_d;
    logic [31:0]      m0_rdata_q, m0_rdata_d;
    logic [31:0]      m1_rdata_q, m1_rdata_d;

    logic             unused_io0_in;
    logic             any_valid, pick_m1, div_end, xfer_done, gap_end;
    logic [31:0]      rx_word;

    assign unused_io0_in = flash_io0_in;

    // Tie goes to the requester that was not served last.
    assign any_valid = m0_valid | m1_valid;
    assign pick_m1   = m1_valid & (~m0_valid | ~last_grant_q);
    assign div_end   = (div_cnt_q == DivW'(CLK_DIV - 1));
    assign xfer_done = (state_q == StShift) & sclk_q & div_end & (bit_cnt_q == 6'd63);
    assign gap_end   = (gap_cnt_q == GapW'(CS_GAP - 1));
    assign rx_word   = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
            sclk_q       <= 1'b0;
            rx_q         <= '0;
            gap_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            m0_ready_q   <= 1'b0;
            m1_ready_q   <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            sclk_q       <= sclk_d;
            rx_q         <= rx_d;
            gap_cnt_q    <= gap_cnt_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            m0_ready_q   <= m0_ready_d;
            m1_ready_q   <= m1_ready_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        div_cnt_d    = div_cnt_q;
        sclk_d       = sclk_q;
        rx_d         = rx_q;
        gap_cnt_d    = gap_cnt_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        m0_ready_d   = 1'b0;
        m1_ready_d   = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    state_d    = StShift;
                    shift_d    = {8'h03, (pick_m1 ? m1_addr : m0_addr), 32'h0};
                    grant_id_d = pick_m1;
                    bit_cnt_d  = '0;
                    div_cnt_d  = '0;
                    sclk_d     = 1'b0;
                end
            end
            StShift: begin
                if (!div_end) begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end else begin
                    div_cnt_d = '0;
                    if (!sclk_q) begin
                        // Rising flash_clk: MISO is sampled only in the data phase.
                        sclk_d = 1'b1;
                        if (bit_cnt_q[5]) begin
                            rx_d = {rx_q[30:0], flash_io1_in};
                        end
                    end else begin
                        sclk_d = 1'b0;
                        if (xfer_done) begin
                            state_d      = StGap;
                            gap_cnt_d    = '0;
                            last_grant_d = grant_id_q;
                            if (grant_id_q) begin
                                m1_ready_d = 1'b1;
                                m1_rdata_d = rx_word;
                            end else begin
                                m0_ready_d = 1'b1;
                                m0_rdata_d = rx_word;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
                            shift_d   = {shift_q[62:0], 1'b0};
                        end
                    end
                end
            end
            StGap: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_end) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        flash_csn     = (state_q != StShift);
        flash_clk     = sclk_q;
        flash_io0_en  = (state_q == StShift) & ~bit_cnt_q[5];
        flash_io0_out = (state_q == StShift) & shift_q[63];
        flash_io1_en  = 1'b0;
        flash_io1_out = 1'b0;
        busy          = (state_q != StIdle);
        grant_id      = grant_id_q;
        m0_ready      = m0_ready_q;
        m1_ready      = m1_ready_q;
        m0_rdata      = m0_rdata_q;
        m1_rdata      = m1_rdata_q;
    end

endmodule
